param_register_file: RTL and testbench

Parametrised accumulator register file: NUM_REGS words of WORD_LENGTH bits, two registered read ports and one write port, plus a registered CZN flag register. It replaces the fixed 4x8 file in the datapath. It adds optional write-to-read bypass, an optional hardwired-zero register 0, a signed-correct N flag, and carry capture from the ALU.

---
 rtl/rf_pkg.sv | 15 +
 rtl/param_register_file_reg.sv | 38 +++
 rtl/param_register_file.sv | 131 +++++++++++++
 tb/tb_param_register_file.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file: bit positions of the
// C, Z and N flags inside the flag register, and the flag vector type.
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int FLAG_C = 0;  // ALU carry
  localparam int FLAG_Z = 1;  // written value is zero
  localparam int FLAG_N = 2;  // written value is negative (sign bit)
  localparam int FLAG_W = 3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/param_register_file_reg.sv
// -----------------------------------------------------------------------------
// param_register_file_reg
// Generic load-enabled storage register with synchronous active-high reset.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, clears out
//   ld   in   1 = capture in on this edge, 0 = hold
//   in   in   WORD_LENGTH data to capture
//   out  out  WORD_LENGTH stored value
// -----------------------------------------------------------------------------
module param_register_file_reg
  import rf_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld,
  input  logic [WORD_LENGTH-1:0] in,
  output logic [WORD_LENGTH-1:0] out
);

  logic [WORD_LENGTH-1:0] r_q;

  // Storage: reset clears, load captures, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= {WORD_LENGTH{1'b0}};
    end else if (ld) begin
      r_q <= in;
    end else begin
      r_q <= r_q;
    end
  end

  assign out = r_q;

endmodule

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// NUM_REGS x WORD_LENGTH accumulator register file with two registered read
// ports, one write port, optional write-to-read bypass, optional hardwired-zero
// register 0, and a registered {N,Z,C} flag register updated with writes.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   read_en                  1 = load read_data1/2 this edge, 0 = hold
//   read_reg1/2              read addresses
//   read_data1/2             registered read data (1-cycle latency)
//   write_reg_en/write_reg/write_data   write port
//   flag_ld, carry_in        flag load strobe (qualified by write_reg_en), ALU carry
//   CZN_from_RF              registered flags: bit0 C, bit1 Z, bit2 N
// -----------------------------------------------------------------------------
module param_register_file
  import rf_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int BYPASS      = 1,
  parameter int R0_ZERO     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_en,
  input  logic [ADDR_W-1:0]      read_reg1,
  input  logic [ADDR_W-1:0]      read_reg2,
  output logic [WORD_LENGTH-1:0] read_data1,
  output logic [WORD_LENGTH-1:0] read_data2,
  input  logic                   write_reg_en,
  input  logic [ADDR_W-1:0]      write_reg,
  input  logic [WORD_LENGTH-1:0] write_data,
  input  logic                   flag_ld,
  input  logic                   carry_in,
  output logic [2:0]             CZN_from_RF
);

  // One extra bit so NUM_REGS itself is representable even when it is a
  // power of two.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [WORD_LENGTH-1:0] w_acc [NUM_REGS];
  logic [NUM_REGS-1:0]    w_ld;
  logic                   w_wr_live;
  logic [WORD_LENGTH-1:0] w_rd1;
  logic [WORD_LENGTH-1:0] w_rd2;
  logic                   w_byp1;
  logic                   w_byp2;
  logic [WORD_LENGTH-1:0] r_rd1;
  logic [WORD_LENGTH-1:0] r_rd2;
  flags_t                 r_czn;

  // An address is "live" when it names a real register that can hold data;
  // a hardwired-zero register 0 is neither writable nor bypassable.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) &&
           !((R0_ZERO != 0) && (a == {ADDR_W{1'b0}}));
  endfunction

  // Per-register load decode, purely combinational from the write port.
  always_comb begin
    w_wr_live = write_reg_en && addr_live(write_reg);
    w_ld      = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_ld[i] = w_wr_live && (write_reg == ADDR_W'(i));
    end
  end

  // Storage: one register instance per word; register 0 tied low when hardwired.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if ((R0_ZERO != 0) && (gi == 0)) begin : g_zero
      assign w_acc[gi] = {WORD_LENGTH{1'b0}};
    end else begin : g_inst
      param_register_file_reg #(
        .WORD_LENGTH(WORD_LENGTH)
      ) u_reg (
        .clk (clk),
        .rst (rst),
        .ld  (w_ld[gi]),
        .in  (write_data),
        .out (w_acc[gi])
      );
    end
  end

  // Read muxes as AND-OR trees; out-of-range addresses select nothing and
  // therefore read 0. Bypass only applies to live addresses.
  always_comb begin
    w_rd1 = {WORD_LENGTH{1'b0}};
    w_rd2 = {WORD_LENGTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd1 = w_rd1 | (w_acc[i] & {WORD_LENGTH{read_reg1 == ADDR_W'(i)}});
      w_rd2 = w_rd2 | (w_acc[i] & {WORD_LENGTH{read_reg2 == ADDR_W'(i)}});
    end
    w_byp1 = (BYPASS != 0) && w_wr_live && (write_reg == read_reg1);
    w_byp2 = (BYPASS != 0) && w_wr_live && (write_reg == read_reg2);
  end

  // Registered read ports: load on read_en, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= {WORD_LENGTH{1'b0}};
      r_rd2 <= {WORD_LENGTH{1'b0}};
    end else if (read_en) begin
      r_rd1 <= w_byp1 ? write_data : w_rd1;
      r_rd2 <= w_byp2 ? write_data : w_rd2;
    end else begin
      r_rd1 <= r_rd1;
      r_rd2 <= r_rd2;
    end
  end

  // Flags follow the ALU result even when the write address was rejected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_czn <= {FLAG_W{1'b0}};
    end else if (write_reg_en && flag_ld) begin
      r_czn[FLAG_C] <= carry_in;
      r_czn[FLAG_Z] <= (write_data == {WORD_LENGTH{1'b0}});
      r_czn[FLAG_N] <= write_data[WORD_LENGTH-1];
    end else begin
      r_czn <= r_czn;
    end
  end

  assign read_data1  = r_rd1;
  assign read_data2  = r_rd2;
  assign CZN_from_RF = r_czn;

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
// Drives three configurations of param_register_file from one stimulus stream:
//   A: 8-bit, 4 regs, bypass on          B: 8-bit, 4 regs, bypass off
//   C: 16-bit, 6 regs, bypass on, hardwired-zero register 0
// A behavioural array model predicts every output each cycle; directed
// literal expectations pin down the key scenarios.
// -----------------------------------------------------------------------------
module tb_param_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, read_en, we, flag_ld, carry;
  logic [2:0]  rr1, rr2, wr;
  logic [15:0] wd;

  logic [7:0]  a_rd1, a_rd2, b_rd1, b_rd2;
  logic [15:0] c_rd1, c_rd2;
  logic [2:0]  a_f, b_f, c_f;

  param_register_file #(.WORD_LENGTH(8), .NUM_REGS(4), .BYPASS(1), .R0_ZERO(0)) dut_a (
    .clk(clk), .rst(rst), .read_en(read_en),
    .read_reg1(rr1[1:0]), .read_reg2(rr2[1:0]),
    .read_data1(a_rd1), .read_data2(a_rd2),
    .write_reg_en(we), .write_reg(wr[1:0]), .write_data(wd[7:0]),
    .flag_ld(flag_ld), .carry_in(carry), .CZN_from_RF(a_f));

  param_register_file #(.WORD_LENGTH(8), .NUM_REGS(4), .BYPASS(0), .R0_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .read_en(read_en),
    .read_reg1(rr1[1:0]), .read_reg2(rr2[1:0]),
    .read_data1(b_rd1), .read_data2(b_rd2),
    .write_reg_en(we), .write_reg(wr[1:0]), .write_data(wd[7:0]),
    .flag_ld(flag_ld), .carry_in(carry), .CZN_from_RF(b_f));

  param_register_file #(.WORD_LENGTH(16), .NUM_REGS(6), .BYPASS(1), .R0_ZERO(1)) dut_c (
    .clk(clk), .rst(rst), .read_en(read_en),
    .read_reg1(rr1), .read_reg2(rr2),
    .read_data1(c_rd1), .read_data2(c_rd2),
    .write_reg_en(we), .write_reg(wr), .write_data(wd),
    .flag_ld(flag_ld), .carry_in(carry), .CZN_from_RF(c_f));

  int checks = 0;
  int errors = 0;

  // Configuration table for the model, indexed 0=A, 1=B, 2=C.
  int cw  [3] = '{8, 8, 16};
  int cn  [3] = '{4, 4, 6};
  int caw [3] = '{2, 2, 3};
  int cb  [3] = '{1, 0, 1};
  int cz  [3] = '{0, 0, 1};

  logic [15:0] m_acc [3][8];
  logic [15:0] m_rd1 [3];
  logic [15:0] m_rd2 [3];
  logic [2:0]  m_f   [3];

  function automatic bit live(int k, int a);
    return (a < cn[k]) && !(cz[k] == 1 && a == 0);
  endfunction

  function automatic logic [15:0] expect_read(int k, int a, int aw, logic [15:0] d);
    if (!live(k, a)) return 16'h0000;
    if (we && a == aw && cb[k] == 1) return d;
    return m_acc[k][a];
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int amask, a1, a2, aw;
    logic [15:0] dmask, d;
    for (int k = 0; k < 3; k++) begin
      amask = (1 << caw[k]) - 1;
      dmask = (cw[k] == 16) ? 16'hFFFF : 16'h00FF;
      a1 = int'(rr1) & amask;
      a2 = int'(rr2) & amask;
      aw = int'(wr) & amask;
      d  = wd & dmask;
      if (rst) begin
        for (int j = 0; j < 8; j++) m_acc[k][j] = 16'h0000;
        m_rd1[k] = 16'h0000;
        m_rd2[k] = 16'h0000;
        m_f[k]   = 3'b000;
      end else begin
        if (read_en) begin
          m_rd1[k] = expect_read(k, a1, aw, d);
          m_rd2[k] = expect_read(k, a2, aw, d);
        end
        if (we && live(k, aw)) m_acc[k][aw] = d;
        if (we && flag_ld) m_f[k] = {d[cw[k]-1], (d == 16'h0000), carry};
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update model, let the DUTs take the edge, compare on negedge.
  task automatic cycle();
    model_step();
    @(negedge clk);
    chk("a_rd1", {8'h00, a_rd1}, m_rd1[0]);
    chk("a_rd2", {8'h00, a_rd2}, m_rd2[0]);
    chk("a_czn", {13'h0, a_f}, {13'h0, m_f[0]});
    chk("b_rd1", {8'h00, b_rd1}, m_rd1[1]);
    chk("b_rd2", {8'h00, b_rd2}, m_rd2[1]);
    chk("b_czn", {13'h0, b_f}, {13'h0, m_f[1]});
    chk("c_rd1", c_rd1, m_rd1[2]);
    chk("c_rd2", c_rd2, m_rd2[2]);
    chk("c_czn", {13'h0, c_f}, {13'h0, m_f[2]});
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; we = 1'b0; flag_ld = 1'b0; carry = 1'b0;
    rr1 = 3'd0; rr2 = 3'd0; wr = 3'd0; wd = 16'h0000;

    // Reset for two cycles.
    cycle();
    cycle();
    chk("lit_reset_rd1", {8'h00, a_rd1}, 16'h0000);
    chk("lit_reset_czn", {13'h0, a_f}, 16'h0000);

    // Basic write then read.
    rst = 1'b0; we = 1'b1; wr = 3'd2; wd = 16'h005A;
    cycle();
    we = 1'b0; read_en = 1'b1; rr1 = 3'd2; rr2 = 3'd0;
    cycle();
    chk("lit_basic_rd1", {8'h00, a_rd1}, 16'h005A);
    chk("lit_basic_rd2", {8'h00, a_rd2}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      rr1 = 3'(i); rr2 = 3'(i);
      cycle();
      chk("lit_basic_scan", {8'h00, a_rd1}, (i == 2) ? 16'h005A : 16'h0000);
    end

    // Bypass vs no bypass on same-edge write/read of reg 1.
    we = 1'b1; wr = 3'd1; wd = 16'h0011; read_en = 1'b0;
    cycle();
    wd = 16'h0033; rr1 = 3'd1; rr2 = 3'd1; read_en = 1'b1;
    cycle();
    chk("lit_byp_a1", {8'h00, a_rd1}, 16'h0033);
    chk("lit_byp_a2", {8'h00, a_rd2}, 16'h0033);
    chk("lit_nobyp_b1", {8'h00, b_rd1}, 16'h0011);
    chk("lit_nobyp_b2", {8'h00, b_rd2}, 16'h0011);
    we = 1'b0;
    cycle();
    chk("lit_nobyp_next", {8'h00, b_rd1}, 16'h0033);

    // Flags.
    read_en = 1'b0; we = 1'b1; wr = 3'd3; wd = 16'h0080; flag_ld = 1'b1; carry = 1'b1;
    cycle();
    chk("lit_flags_neg", {13'h0, a_f}, 16'h0005);
    chk("lit_flags_c16", {13'h0, c_f}, 16'h0001);
    wd = 16'h0000; carry = 1'b0;
    cycle();
    chk("lit_flags_zero", {13'h0, a_f}, 16'h0002);
    wd = 16'h007F; flag_ld = 1'b0; carry = 1'b1;
    cycle();
    chk("lit_flags_hold", {13'h0, a_f}, 16'h0002);

    // Hold with read_en low while writes occur.
    we = 1'b0; read_en = 1'b1; rr1 = 3'd3;
    cycle();
    chk("lit_hold_pre", {8'h00, a_rd1}, 16'h007F);
    read_en = 1'b0; we = 1'b1; wr = 3'd3; wd = 16'h0055;
    cycle();
    wd = 16'h0066;
    cycle();
    chk("lit_hold", {8'h00, a_rd1}, 16'h007F);

    // Reset in the same cycle as a write with flag load.
    rst = 1'b1; we = 1'b1; wr = 3'd3; wd = 16'h00FF; flag_ld = 1'b1; carry = 1'b1; read_en = 1'b1;
    cycle();
    rst = 1'b0; we = 1'b0; flag_ld = 1'b0; rr1 = 3'd3; read_en = 1'b1;
    cycle();
    chk("lit_rst_rd", {8'h00, a_rd1}, 16'h0000);
    chk("lit_rst_czn", {13'h0, a_f}, 16'h0000);

    // Generalised config C: hardwired zero, out-of-range address, N flag.
    we = 1'b1; wr = 3'd0; wd = 16'hBEEF; read_en = 1'b0;
    cycle();
    we = 1'b0; read_en = 1'b1; rr1 = 3'd0;
    cycle();
    chk("lit_r0_zero", c_rd1, 16'h0000);
    we = 1'b1; wr = 3'd7; wd = 16'h1234; read_en = 1'b0;
    cycle();
    we = 1'b0; read_en = 1'b1; rr1 = 3'd7;
    cycle();
    chk("lit_oob_read", c_rd1, 16'h0000);
    we = 1'b1; wr = 3'd5; wd = 16'h8001; flag_ld = 1'b1; carry = 1'b0; read_en = 1'b0;
    cycle();
    chk("lit_c_nflag", {13'h0, c_f}, 16'h0004);
    we = 1'b0; flag_ld = 1'b0; read_en = 1'b1; rr1 = 3'd5;
    cycle();
    chk("lit_c_rd5", c_rd1, 16'h8001);

    // Sweep: write i*3+1 everywhere, read mirrored pairs.
    read_en = 1'b0; we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr = 3'(i); wd = 16'(i * 3 + 1);
      cycle();
    end
    we = 1'b0; read_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rr1 = 3'(i); rr2 = 3'(5 - i);
      cycle();
      chk("lit_sweep1", c_rd1, (i == 0) ? 16'h0000 : 16'(i * 3 + 1));
      chk("lit_sweep2", c_rd2, (i == 5) ? 16'h0000 : 16'(16 - i * 3));
    end

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      read_en = 1'($urandom_range(0, 1));
      we      = 1'($urandom_range(0, 1));
      flag_ld = 1'($urandom_range(0, 1));
      carry   = 1'($urandom_range(0, 1));
      wr      = 3'($urandom_range(0, 7));
      rr1     = 3'($urandom_range(0, 7));
      rr2     = 3'($urandom_range(0, 7));
      wd      = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rr1 = wr;
      if ($urandom_range(0, 3) == 0) rr2 = wr;
      if ($urandom_range(0, 7) == 0) wd = 16'h0000;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
